// File: rtl/alu32_pkg.sv
// Shared opcodes, FSM state type and status-word bit positions for alu_32.
// The ALU32_MUL_EN macro enables the multiplier (opcodes B/C); by default they decode as illegal.
package alu32_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_MULH = 4'hC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DONE_BIT = 0;
    localparam int ILL_BIT  = 1;
    localparam int Z_BIT    = 2;
    localparam int C_BIT    = 3;
    localparam int V_BIT    = 4;
    localparam int N_BIT    = 5;

endpackage

// File: rtl/alu32_mul_seq.sv
// Iterative 32x32 unsigned shift-add multiplier, one partial product per cycle.
// product is the accumulator value after the current step, valid with done.
module alu32_mul_seq
    import alu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic [63:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        product  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        done     = busy_q && (cnt_q == 5'(MUL_CYCLES - 1));
        if (busy_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (done) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            mcand_d  = {32'd0, a};
            mplier_d = b;
            acc_d    = 64'd0;
            cnt_d    = 5'd0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= 64'd0;
            acc_q    <= 64'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_32.sv
// 32-bit registered ALU; single-cycle logic/arith, optional 32-cycle multiply.
// Define ALU32_MUL_EN to build the multiplier and BUSY state.
module alu_32
    import alu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic [31:0] opdone
);

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  flags_q, flags_d;

    logic [32:0] sum33, diff33;
    logic [31:0] alu_res;
    logic        alu_c, alu_v, alu_ill;
    logic [4:0]  shamt;

`ifdef ALU32_MUL_EN
    logic        mulh_q, mulh_d;
    logic        mul_start, mul_busy, mul_done;
    logic [63:0] mul_prod;
    logic [31:0] mul_res;
    logic        is_mul;

    assign is_mul  = (op == OP_MUL) || (op == OP_MULH);
    assign mul_res = mulh_q ? mul_prod[63:32] : mul_prod[31:0];

    alu32_mul_seq u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    assign sum33  = {1'b0, a} + {1'b0, b};
    assign diff33 = {1'b0, a} - {1'b0, b};
    assign shamt  = b[4:0];

    always_comb begin
        alu_res = 32'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum33[31:0];
                alu_c   = sum33[32];
                alu_v   = (a[31] == b[31]) && (sum33[31] != a[31]);
            end
            OP_SUB: begin
                alu_res = diff33[31:0];
                alu_c   = ~diff33[32];
                alu_v   = (a[31] != b[31]) && (diff33[31] != a[31]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = 32'($signed(a) >>> shamt);
            OP_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {31'd0, a < b};
`ifdef ALU32_MUL_EN
            OP_MUL, OP_MULH: alu_res = 32'd0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU32_MUL_EN
        mulh_d    = mulh_q;
        mul_start = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef ALU32_MUL_EN
                if (is_mul) begin
                    flags_d[DONE_BIT] = 1'b0;
                    mul_start         = 1'b1;
                    mulh_d            = (op == OP_MULH);
                    state_d           = ST_BUSY;
                end else
`endif
                begin
                    flags_d           = 6'd0;
                    flags_d[DONE_BIT] = 1'b1;
                    if (alu_ill) begin
                        // Illegal ops report only done+illegal, no result flags.
                        result_d         = 32'd0;
                        flags_d[ILL_BIT] = 1'b1;
                    end else begin
                        result_d       = alu_res;
                        flags_d[Z_BIT] = (alu_res == 32'd0);
                        flags_d[C_BIT] = alu_c;
                        flags_d[V_BIT] = alu_v;
                        flags_d[N_BIT] = alu_res[31];
                    end
                end
            end
            ST_BUSY: begin
`ifdef ALU32_MUL_EN
                if (mul_done) begin
                    result_d          = mul_res;
                    flags_d           = 6'd0;
                    flags_d[DONE_BIT] = 1'b1;
                    flags_d[Z_BIT]    = (mul_res == 32'd0);
                    flags_d[N_BIT]    = mul_res[31];
                    state_d           = ST_IDLE;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= 32'd0;
            flags_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU32_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mulh_q <= 1'b0;
        end else begin
            mulh_q <= mulh_d;
        end
    end
`endif

    assign result = result_q;
    assign opdone = {26'd0, flags_q};

endmodule

// File: tb/tb_alu_32.sv
// Directed scoreboard bench for alu_32; multiply checks follow ALU32_MUL_EN.
module tb_alu_32;
    import alu32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] result, opdone;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] opd;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_32 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .opdone (opdone)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [31:0] eo);
        exp_t e;
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        e.tag = tag;
        e.res = er;
        e.opd = eo;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_res"}, result, e.res);
            chk({e.tag, "_opd"}, opdone, e.opd);
        end
    endtask

    task automatic single(input string tag, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic [31:0] eo);
        drive(tag, o, x, y, er, eo);
        @(posedge clk);
        #1;
        collect();
    endtask

`ifdef ALU32_MUL_EN
    task automatic mul(input string tag, input logic [3:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [31:0] eo);
        int cyc;
        logic [31:0] held;
        held = result;
        drive(tag, o, x, y, er, eo);
        @(posedge clk);
        #1;
        chk({tag, "_launch_done"}, {31'd0, opdone[DONE_BIT]}, 32'd0);
        chk({tag, "_launch_hold"}, result, held);
        a  = 32'h1234_5678;
        b  = 32'hFFFF_0000;
        op = OP_XOR;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (opdone[DONE_BIT]) begin
                cyc = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd32);
        collect();
    endtask
`endif

    initial begin
        logic [7:0] wide_op;
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        op  = OP_ADD;
        #12;
        chk("reset_result", result, 32'd0);
        chk("reset_opdone", opdone, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        single("add",  OP_ADD,  32'h5, 32'h16, 32'h0000_001B, 32'h01);
        single("sub",  OP_SUB,  32'h5, 32'h16, 32'hFFFF_FFEF, 32'h21);
        single("and",  OP_AND,  32'h5, 32'h16, 32'h0000_0004, 32'h01);
        single("or",   OP_OR,   32'h5, 32'h16, 32'h0000_0017, 32'h01);
        single("xor",  OP_XOR,  32'h5, 32'h16, 32'h0000_0013, 32'h01);
        single("nor",  OP_NOR,  32'h5, 32'h16, 32'hFFFF_FFE8, 32'h21);
        single("sll",  OP_SLL,  32'h5, 32'h16, 32'h0140_0000, 32'h01);
        single("srl",  OP_SRL,  32'h5, 32'h16, 32'h0000_0000, 32'h05);
        single("sra",  OP_SRA,  32'h5, 32'h16, 32'h0000_0000, 32'h05);
        single("slt",  OP_SLT,  32'h5, 32'h16, 32'h0000_0001, 32'h01);
        single("sltu", OP_SLTU, 32'h5, 32'h16, 32'h0000_0001, 32'h01);

        single("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h31);
        single("add_carry", OP_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 32'h0D);
        single("sub_nb",    OP_SUB,  32'h16, 32'h5, 32'h0000_0011, 32'h09);
        single("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h19);
        single("sra_neg",   OP_SRA,  32'h8000_0000, 32'h21, 32'hC000_0000, 32'h21);
        single("sll_wrap",  OP_SLL,  32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h21);
        single("slt_neg",   OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 32'h01);
        single("sltu_big",  OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 32'h05);
        single("hold1",     OP_XOR,  32'hA5A5_0000, 32'h0F0F_FFFF, 32'hAAAA_FFFF, 32'h21);
        single("hold2",     OP_XOR,  32'hA5A5_0000, 32'h0F0F_FFFF, 32'hAAAA_FFFF, 32'h21);

        single("ill_d", 4'hD, 32'h5, 32'h16, 32'h0, 32'h3);
        single("ill_f", 4'hF, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h3);
        wide_op = 8'h12;
        single("op_trunc", wide_op[3:0], 32'h5, 32'h16, 32'h4, 32'h01);

`ifdef ALU32_MUL_EN
        mul("mul",  OP_MUL,  32'h5, 32'h16, 32'h0000_006E, 32'h01);
        mul("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h21);
        mul("mul_lo", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h01);
        single("after_mul", OP_ADD, 32'h1, 32'h2, 32'h3, 32'h01);

        @(negedge clk);
        op = OP_MUL;
        a  = 32'h7;
        b  = 32'h9;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("busy_rst_result", result, 32'd0);
        chk("busy_rst_opdone", opdone, 32'd0);
        @(negedge clk);
        op = OP_ADD;
        a  = 32'h10;
        b  = 32'h20;
        @(negedge clk);
        rst = 1'b0;
        single("post_abort", OP_ADD, 32'h10, 32'h20, 32'h30, 32'h01);
`else
        single("mul_off",  OP_MUL,  32'h5, 32'h16, 32'h0, 32'h3);
        single("mulh_off", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h3);
`endif

        single("pre_rst", OP_OR, 32'hF0, 32'h0F, 32'hFF, 32'h01);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_opdone", opdone, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        single("post_rst", OP_SUB, 32'h3, 32'h3, 32'h0, 32'h0D);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
